student_iic_target: RTL and testbench

STUDENT_IIC_TARGET -- requirements
Module: student_iic_target

---
 rtl/student_iic_target_pkg.sv | 20 ++
 rtl/student_iic_sync_edge.sv | 22 ++
 rtl/student_iic_target.sv | 153 +++++++++++++++
 tb/tb_student_iic_target.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/student_iic_target_pkg.sv
// student_iic_target_pkg: shared state type and bus ACK levels for the I2C target
package student_iic_target_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        WAIT_STOP
    } state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/student_iic_sync_edge.sv
// student_iic_sync_edge: 2-flop synchronizer plus edge-detect flop for one bus line
module student_iic_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] ff;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ff <= 3'b111;
        else ff <= {ff[1:0], d_i};
    end

    assign q_o    = ff[1];
    assign rise_o = ff[1] & ~ff[2];
    assign fall_o = ~ff[1] & ff[2];

endmodule

// File: rtl/student_iic_target.sv
// student_iic_target: I2C register-file target with an auto-incrementing pointer
module student_iic_target
    import student_iic_target_pkg::*;
#(
    parameter logic [6:0]  DevAddr  = 7'h50,
    parameter int unsigned PtrWidth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                scl_i,
    input  logic                sda_i,
    output logic                sda_oe_o,
    output logic                wr_valid_o,
    output logic [PtrWidth-1:0] wr_addr_o,
    output logic [7:0]          wr_data_o,
    output logic [PtrWidth-1:0] rd_addr_o,
    input  logic [7:0]          rd_data_i,
    output logic                busy_o
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    student_iic_sync_edge u_scl (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (scl_i),
        .q_o   (scl_s),
        .rise_o(scl_rise),
        .fall_o(scl_fall)
    );

    student_iic_sync_edge u_sda (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (sda_i),
        .q_o   (sda_s),
        .rise_o(sda_rise),
        .fall_o(sda_fall)
    );

    state_e              state;
    logic [2:0]          bit_cnt;
    logic [6:0]          rx_sr;
    logic [7:0]          tx_sr;
    logic [PtrWidth-1:0] ptr;
    logic                rw;
    logic                start_det, stop_det, last_bit;
    logic [7:0]          rx_byte;

    assign start_det = scl_s & sda_fall;
    assign stop_det  = scl_s & sda_rise;
    assign last_bit  = (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr, sda_s};
    assign rd_addr_o = ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            ptr        <= '0;
            rw         <= 1'b0;
            sda_oe_o   <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            busy_o     <= 1'b0;
        end else begin
            wr_valid_o <= 1'b0;
            if (stop_det) begin
                state    <= IDLE;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else if (start_det) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                sda_oe_o <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: if (scl_rise) begin
                        rx_sr   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            case (state)
                                ADDR: if (rx_byte[7:1] == DevAddr) begin
                                    state  <= ADDR_ACK;
                                    rw     <= rx_byte[0];
                                    busy_o <= 1'b1;
                                end else begin
                                    state  <= IDLE;
                                    busy_o <= 1'b0;
                                end
                                PTR: begin
                                    ptr   <= rx_byte[PtrWidth-1:0];
                                    state <= PTR_ACK;
                                end
                                default: begin
                                    wr_valid_o <= 1'b1;
                                    wr_addr_o  <= ptr;
                                    wr_data_o  <= rx_byte;
                                    state      <= WDATA_ACK;
                                end
                            endcase
                        end
                    end
                    // First fall drives the ACK, second fall ends the slot
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        sda_oe_o <= ~sda_oe_o;
                        if (sda_oe_o) begin
                            case (state)
                                ADDR_ACK: if (rw) begin
                                    tx_sr    <= rd_data_i;
                                    sda_oe_o <= ~rd_data_i[7];
                                    state    <= RDATA;
                                end else begin
                                    state <= PTR;
                                end
                                PTR_ACK: state <= WDATA;
                                default: begin
                                    ptr   <= ptr + 1'b1;
                                    state <= WDATA;
                                end
                            endcase
                        end
                    end
                    RDATA: if (scl_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_o <= 1'b0;
                            state    <= RACK;
                        end else begin
                            tx_sr    <= {tx_sr[6:0], 1'b0};
                            sda_oe_o <= ~tx_sr[6];
                        end
                    end
                    RACK: if (scl_rise) begin
                        if (sda_s == NACK) state <= WAIT_STOP;
                        else ptr <= ptr + 1'b1;
                    end else if (scl_fall) begin
                        tx_sr    <= rd_data_i;
                        sda_oe_o <= ~rd_data_i[7];
                        state    <= RDATA;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_student_iic_target.sv
// tb_student_iic_target: directed I2C master transactions against the target with a register-file parent model
module tb_student_iic_target;

    localparam int Q = 1000;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic       scl    = 1'b1;
    logic       m_sda  = 1'b1;
    logic       sda_line;
    logic       sda_oe_o, wr_valid_o, busy_o;
    logic [3:0] wr_addr_o, rd_addr_o;
    logic [7:0] wr_data_o, rd_data_i;

    int vectors = 0, miscompares = 0;
    int wv_n = 0, oe_n = 0, busy_n = 0, glitch_n = 0;
    logic [3:0] wv_a [0:15];
    logic [7:0] wv_d [0:15];
    logic oe_q = 1'b0;

    assign sda_line  = m_sda & ~sda_oe_o;
    assign rd_data_i = 8'hF0 + {4'h0, rd_addr_o};

    always #10 clk_i = ~clk_i;

    student_iic_target #(.DevAddr(7'h50), .PtrWidth(4)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .scl_i     (scl),
        .sda_i     (sda_line),
        .sda_oe_o  (sda_oe_o),
        .wr_valid_o(wr_valid_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i),
        .busy_o    (busy_o)
    );

    always @(negedge clk_i) begin
        if (wr_valid_o && wv_n < 16) begin
            wv_a[wv_n] = wr_addr_o;
            wv_d[wv_n] = wr_data_o;
        end
        if (wr_valid_o) wv_n++;
        if (sda_oe_o) oe_n++;
        if (busy_o) busy_n++;
        if (rst_ni && !oe_q && sda_oe_o)
            assert (!scl) else begin
                glitch_n++;
                $error("FAIL sda_oe_rise_scl_high: scl=%b required 0", scl);
            end
        oe_q = sda_oe_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_c();
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic stop_c();
        m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(ack);
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;
        logic [3:0] nib;
        int         n0, o0, b0;
        #100;
        chk("rst_sda_oe", sda_oe_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_wr_valid", wr_valid_o, 0);
        chk("rst_wr_addr", wr_addr_o, 0);
        chk("rst_wr_data", wr_data_o, 0);
        chk("rst_rd_addr", rd_addr_o, 0);
        rst_ni = 1'b1; #Q;

        start_c();
        write_byte(8'hA0, ack); chk("t1_addr_ack", ack, 0);
        chk("t1_busy_hi", busy_o, 1);
        write_byte(8'h03, ack); chk("t1_ptr_ack", ack, 0);
        write_byte(8'h11, ack); chk("t1_d0_ack", ack, 0);
        write_byte(8'h22, ack); chk("t1_d1_ack", ack, 0);
        stop_c(); #Q;
        chk("t1_wv_count", wv_n, 2);
        chk("t1_wv0_addr", wv_a[0], 4'h3);
        chk("t1_wv0_data", wv_d[0], 8'h11);
        chk("t1_wv1_addr", wv_a[1], 4'h4);
        chk("t1_wv1_data", wv_d[1], 8'h22);
        chk("t1_busy_lo", busy_o, 0);

        n0 = wv_n;
        start_c();
        write_byte(8'hA0, ack); chk("t2_addr_ack", ack, 0);
        write_byte(8'h0F, ack); chk("t2_ptr_ack", ack, 0);
        chk("t2_ptr_set", rd_addr_o, 4'hF);
        start_c();
        write_byte(8'hA1, ack); chk("t2_raddr_ack", ack, 0);
        read_byte(1'b0, d); chk("t2_rd0", d, 8'hFF);
        chk("t2_ptr_wrap", rd_addr_o, 4'h0);
        read_byte(1'b1, d); chk("t2_rd1", d, 8'hF0);
        chk("t2_oe_after_nack", sda_oe_o, 0);
        chk("t2_ptr_after_nack", rd_addr_o, 4'h0);
        stop_c(); #Q;
        chk("t2_busy_lo", busy_o, 0);
        chk("t2_no_writes", wv_n, n0);

        n0 = wv_n; o0 = oe_n; b0 = busy_n;
        start_c();
        write_byte(8'hA2, ack); chk("t3_addr_nack", ack, 1);
        write_byte(8'h01, ack); chk("t3_b0_nack", ack, 1);
        write_byte(8'h02, ack);
        write_byte(8'h03, ack); chk("t3_b2_nack", ack, 1);
        stop_c(); #Q;
        chk("t3_oe_never", oe_n, o0);
        chk("t3_busy_never", busy_n, b0);
        chk("t3_no_writes", wv_n, n0);

        n0 = wv_n;
        start_c();
        write_byte(8'hA0, ack);
        write_byte(8'h07, ack); chk("t4_ptr_ack", ack, 0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        stop_c(); #Q;
        chk("t4_no_write", wv_n, n0);
        chk("t4_oe_lo", sda_oe_o, 0);
        chk("t4_busy_lo", busy_o, 0);
        start_c();
        write_byte(8'hA0, ack); chk("t4_next_addr_ack", ack, 0);
        write_byte(8'h02, ack);
        write_byte(8'h5A, ack); chk("t4_next_d_ack", ack, 0);
        stop_c(); #Q;
        chk("t4_next_count", wv_n, n0 + 1);
        chk("t4_next_addr", wv_a[n0], 4'h2);
        chk("t4_next_data", wv_d[n0], 8'h5A);

        n0 = wv_n;
        start_c();
        write_byte(8'hA0, ack);
        write_byte(8'h05, ack);
        start_c();
        write_byte(8'hA1, ack); chk("t5_raddr_ack", ack, 0);
        nib = 4'h0;
        for (int i = 0; i < 4; i++) begin
            recv_bit(b);
            nib = {nib[2:0], b};
        end
        chk("t5_hi_nibble", nib, 4'hF);
        chk("t5_driving_zero", sda_oe_o, 1);
        rst_ni = 1'b0; #1;
        chk("t5_async_oe", sda_oe_o, 0);
        chk("t5_async_ptr", rd_addr_o, 4'h0);
        chk("t5_async_busy", busy_o, 0);
        #(Q-1); rst_ni = 1'b1; #Q;
        stop_c(); #Q;
        chk("t5_no_write", wv_n, n0);
        start_c();
        write_byte(8'hA0, ack); chk("t5_after_addr_ack", ack, 0);
        write_byte(8'h09, ack);
        write_byte(8'h77, ack); chk("t5_after_d_ack", ack, 0);
        stop_c(); #Q;
        chk("t5_after_count", wv_n, n0 + 1);
        chk("t5_after_addr", wv_a[n0], 4'h9);
        chk("t5_after_data", wv_d[n0], 8'h77);

        chk("oe_glitches", glitch_n, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
